// File: rtl/conv_pkg.sv
// Shared geometry, FSM encoding and tap offset tables for the 3x3 window sequencers.
// Image dimensions must be powers of two so {row,col} concatenation forms the pixel address.
package conv_pkg;

  localparam int IMG_W   = 64;
  localparam int IMG_H   = 64;
  localparam int XW      = $clog2(IMG_W);
  localparam int YW      = $clog2(IMG_H);
  localparam int AW      = XW + YW;
  localparam int MAC_LAT = 2;
  localparam int NTAP    = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef logic signed [1:0] ofs_t;

  localparam ofs_t TAP_DY [NTAP] = '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};
  localparam ofs_t TAP_DX [NTAP] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1};

  // Tap numbers beyond the window map to the centre so stray indices never read out of range.
  function automatic ofs_t tap_dy(input logic [3:0] idx);
    return (idx < 4'(NTAP)) ? TAP_DY[idx] : 2'sd0;
  endfunction

  function automatic ofs_t tap_dx(input logic [3:0] idx);
    return (idx < 4'(NTAP)) ? TAP_DX[idx] : 2'sd0;
  endfunction

endpackage

// File: rtl/conv_tap_addr.sv
// Combinational tap address generator: {row,col,tap} -> image address plus zero-pad flag.
// Zero latency, no flow control; also used by the max-pool sequencer.
module conv_tap_addr
  import conv_pkg::*;
(
  input  logic [YW-1:0] row,
  input  logic [XW-1:0] col,
  input  logic [3:0]    tap_idx,
  output logic [AW-1:0] iaddr,
  output logic          pad
);

  logic signed [AW:0] r;
  logic signed [AW:0] c;
  ofs_t               dy;
  ofs_t               dx;

  always_comb begin
    dy = tap_dy(tap_idx);
    dx = tap_dx(tap_idx);
    r  = $signed({{(AW+1-YW){1'b0}}, row}) + $signed({{(AW-1){dy[1]}}, dy});
    c  = $signed({{(AW+1-XW){1'b0}}, col}) + $signed({{(AW-1){dx[1]}}, dx});
    // Negative shows as the sign bit; overflow past a power-of-two edge shows in the upper bits.
    pad   = r[AW] | (|r[AW-1:YW]) | c[AW] | (|c[AW-1:XW]);
    iaddr = pad ? '0 : {r[YW-1:0], c[XW-1:0]};
  end

endmodule

// File: rtl/conv_win_seq.sv
// Raster-order 3x3 convolution sequencer: 9 tap reads, MAC drain, then a req/ack pixel write.
// 13 cycles per pixel with wr_ack held high; only wr_ack can stall, FETCH/DRAIN always advance.
module conv_win_seq
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  output logic          tap_vld,
  output logic [3:0]    tap_idx,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          acc_zero,
  output logic          wr_req,
  input  logic          wr_ack,
  output logic [AW-1:0] caddr_wr,
  output logic          done
);

  localparam int DW = $clog2(MAC_LAT + 1);

  state_t          state_q, state_d;
  logic [YW-1:0]   row_q, row_d;
  logic [XW-1:0]   col_q, col_d;
  logic [3:0]      tap_q, tap_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic [AW-1:0]   iaddr_q, iaddr_d;
  logic            pad_q, pad_d;
  logic            tap_vld_q, tap_vld_d;
  logic [3:0]      tap_idx_q, tap_idx_d;
  logic            acc_en_q, acc_en_d;
  logic            acc_zero_q, acc_zero_d;
  logic            acc_clr_q, acc_clr_d;
  logic            busy_q, busy_d;
  logic            wr_req_q, wr_req_d;
  logic [AW-1:0]   caddr_q, caddr_d;
  logic            done_q, done_d;
  logic            fetch_d;
  logic [AW-1:0]   ta_addr;
  logic            ta_pad;

  // Addresses are computed from next-state counters so every output leaves a flop.
  conv_tap_addr u_tap_addr (
    .row     (row_d),
    .col     (col_d),
    .tap_idx (tap_d),
    .iaddr   (ta_addr),
    .pad     (ta_pad)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tap_d   = tap_q;
    drn_d   = drn_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          row_d   = '0;
          col_d   = '0;
          tap_d   = '0;
        end
      end
      ST_FETCH: begin
        if (tap_q == 4'(NTAP - 1)) begin
          state_d = ST_DRAIN;
          drn_d   = '0;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (drn_q == DW'(MAC_LAT)) state_d = ST_WRITE;
        else                       drn_d   = drn_q + 1'b1;
      end
      ST_WRITE: begin
        if (wr_ack) begin
          tap_d = '0;
          if ((&row_q) && (&col_q)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            col_d   = col_q + 1'b1;
            if (&col_q) row_d = row_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    fetch_d    = (state_d == ST_FETCH);
    tap_vld_d  = fetch_d;
    tap_idx_d  = fetch_d ? tap_d : '0;
    iaddr_d    = fetch_d ? ta_addr : '0;
    pad_d      = fetch_d & ta_pad;
    // Accumulator strobes trail the tap issue by one cycle to line up with returning idata.
    acc_en_d   = tap_vld_q;
    acc_zero_d = tap_vld_q & pad_q;
    acc_clr_d  = tap_vld_q & (tap_idx_q == 4'd0);
    busy_d     = (state_d != ST_IDLE);
    wr_req_d   = (state_d == ST_WRITE);
    caddr_d    = wr_req_d ? {row_d, col_d} : '0;
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      tap_q      <= '0;
      drn_q      <= '0;
      iaddr_q    <= '0;
      pad_q      <= 1'b0;
      tap_vld_q  <= 1'b0;
      tap_idx_q  <= '0;
      acc_en_q   <= 1'b0;
      acc_zero_q <= 1'b0;
      acc_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      caddr_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      tap_q      <= tap_d;
      drn_q      <= drn_d;
      iaddr_q    <= iaddr_d;
      pad_q      <= pad_d;
      tap_vld_q  <= tap_vld_d;
      tap_idx_q  <= tap_idx_d;
      acc_en_q   <= acc_en_d;
      acc_zero_q <= acc_zero_d;
      acc_clr_q  <= acc_clr_d;
      busy_q     <= busy_d;
      wr_req_q   <= wr_req_d;
      caddr_q    <= caddr_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign iaddr    = iaddr_q;
  assign tap_vld  = tap_vld_q;
  assign tap_idx  = tap_idx_q;
  assign acc_clr  = acc_clr_q;
  assign acc_en   = acc_en_q;
  assign acc_zero = acc_zero_q;
  assign wr_req   = wr_req_q;
  assign caddr_wr = caddr_q;
  assign done     = done_q;

endmodule

// File: tb/tb_conv_win_seq.sv
// Scoreboard bench for conv_win_seq: stimulus queues expected taps/writes, a negedge monitor checks them.
module tb_conv_win_seq;

  logic        clk = 1'b0;
  logic        reset, start, wr_ack;
  logic        busy, tap_vld, acc_clr, acc_en, acc_zero, wr_req, done;
  logic [11:0] iaddr, caddr_wr;
  logic [3:0]  tap_idx;

  typedef struct packed {
    logic [11:0] a;
    logic [3:0]  idx;
    logic        pad;
  } tap_t;

  tap_t        tq[$];
  tap_t        aq[$];
  logic [11:0] wq[$];

  int total = 0, bad = 0;
  int wr_cnt = 0, busy_cyc = 0, done_cnt = 0;

  // Hand-derived windows for the corner and interior directed pixels.
  int h0_a    [9] = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
  int h0_p    [9] = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
  int h65_a   [9] = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
  int h4095_a [9] = '{4030, 4031, 0, 4094, 4095, 0, 0, 0, 0};
  int h4095_p [9] = '{0, 0, 1, 0, 0, 1, 1, 1, 1};

  conv_win_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .iaddr    (iaddr),
    .tap_vld  (tap_vld),
    .tap_idx  (tap_idx),
    .acc_clr  (acc_clr),
    .acc_en   (acc_en),
    .acc_zero (acc_zero),
    .wr_req   (wr_req),
    .wr_ack   (wr_ack),
    .caddr_wr (caddr_wr),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_iaddr"}, iaddr, 0);
    chk({tag, "_tap_vld"}, tap_vld, 0);
    chk({tag, "_tap_idx"}, tap_idx, 0);
    chk({tag, "_acc_clr"}, acc_clr, 0);
    chk({tag, "_acc_en"}, acc_en, 0);
    chk({tag, "_acc_zero"}, acc_zero, 0);
    chk({tag, "_wr_req"}, wr_req, 0);
    chk({tag, "_caddr_wr"}, caddr_wr, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic push_pixel(input int p);
    tap_t e;
    int   r, c, a;
    bit   pd;
    for (int i = 0; i < 9; i++) begin
      r  = p / 64 + i / 3 - 1;
      c  = p % 64 + i % 3 - 1;
      pd = (r < 0) || (r > 63) || (c < 0) || (c > 63);
      a  = pd ? 0 : r * 64 + c;
      if (p == 0) begin
        a  = h0_a[i];
        pd = (h0_p[i] != 0);
      end else if (p == 65) begin
        a  = h65_a[i];
        pd = 1'b0;
      end else if (p == 4095) begin
        a  = h4095_a[i];
        pd = (h4095_p[i] != 0);
      end
      e.a   = 12'(a);
      e.idx = 4'(i);
      e.pad = pd;
      tq.push_back(e);
    end
    wq.push_back(12'(p));
  endtask

  task automatic clear_queues();
    tq.delete();
    aq.delete();
    wq.delete();
  endtask

  task automatic ack_pixels(input int first, input int last);
    int n;
    for (int p = first; p <= last; p++) begin
      n = 0;
      while (!wr_req && n < 100) begin
        step();
        n++;
      end
      chk("wr_req_seen", wr_req, 1);
      if (p == 10) begin
        for (int k = 0; k < 5; k++) begin
          if (k == 0) start = 1'b1;
          chk("stall_wr_req", wr_req, 1);
          chk("stall_caddr", caddr_wr, 10);
          chk("stall_tap_vld", tap_vld, 0);
          step();
          start = 1'b0;
        end
        chk("stall_wr_req_last", wr_req, 1);
        chk("stall_caddr_last", caddr_wr, 10);
      end
      wr_ack = 1'b1;
      step();
      wr_ack = 1'b0;
      if (p == 50) begin
        start = 1'b1;
        step();
        start = 1'b0;
      end
    end
  endtask

  // Monitor: acc strobes are checked before the current tap is queued for its acc cycle.
  always @(negedge clk) begin
    tap_t e;
    tap_t ea;
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (acc_en) begin
      if (aq.size() == 0) chk("acc_en_no_expect", acc_en, 0);
      else begin
        ea = aq.pop_front();
        chk("acc_zero", acc_zero, ea.pad);
        chk("acc_clr", acc_clr, ea.idx == 4'd0);
      end
    end else begin
      chk("acc_strobes_idle", {acc_zero, acc_clr}, 0);
    end
    if (tap_vld) begin
      if (tq.size() == 0) chk("tap_vld_no_expect", tap_vld, 0);
      else begin
        e = tq.pop_front();
        chk("tap_iaddr", iaddr, e.a);
        chk("tap_idx", tap_idx, e.idx);
        aq.push_back(e);
      end
    end
    if (wr_req && wr_ack) begin
      if (wq.size() == 0) chk("wr_req_no_expect", wr_req, 0);
      else begin
        chk("caddr_wr", caddr_wr, wq.pop_front());
        wr_cnt++;
      end
    end
  end

  initial begin
    int n;
    reset  = 1'b1;
    start  = 1'b0;
    wr_ack = 1'b0;
    repeat (3) step();
    chk_idle("reset");
    reset = 1'b0;
    step();
    chk_idle("post_reset");

    // Full frame with the writer always ready.
    for (int p = 0; p < 4096; p++) push_pixel(p);
    wr_ack   = 1'b1;
    busy_cyc = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    start    = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 60000) begin
      step();
      n++;
    end
    chk("frame_done_seen", done, 1);
    chk("done_busy", busy, 1);
    chk("done_wr_cnt", wr_cnt, 4096);
    step();
    chk("busy_fall", busy, 0);
    chk("done_one_cycle", done, 0);
    step();
    chk("busy_cycles", busy_cyc, 53249);
    chk("done_count", done_cnt, 1);
    chk("tq_empty", tq.size(), 0);
    chk("aq_empty", aq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    wr_ack = 1'b0;

    // Stalled writer, ignored mid-frame starts, abort during pixel 100.
    clear_queues();
    for (int p = 0; p <= 100; p++) push_pixel(p);
    wr_cnt = 0;
    start  = 1'b1;
    step();
    start = 1'b0;
    ack_pixels(0, 99);
    repeat (3) step();
    chk("abort_in_fetch", tap_vld, 1);
    reset = 1'b1;
    step();
    chk_idle("abort");
    chk("abort_wr_cnt", wr_cnt, 100);
    clear_queues();
    reset = 1'b0;
    step();
    chk_idle("abort_release");

    // Restart from pixel 0, then reset and start together.
    for (int p = 0; p <= 2; p++) push_pixel(p);
    wr_cnt = 0;
    start  = 1'b1;
    step();
    start = 1'b0;
    ack_pixels(0, 1);
    chk("restart_wr_cnt", wr_cnt, 2);
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    step();
    chk_idle("reset_wins");
    clear_queues();
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
